mannix_layer_sched: RTL and testbench

- Layer scheduler for the mannix accelerator. Software pushes layer descriptors into a small command FIFO.
- The block dispatches descriptors in order, one at a time, to the CNN, POOL, FC or ACTIV engine.
  - Drives that engine's address bus and go strobe.
  - Waits for the engine's completion, then retires the descriptor and starts the next.
- Sits between the software register file and the compute engines; the memory farm is untouched.

---
 rtl/mannix_layer_sched.sv | 175 +++++++++++++++++
 tb/tb_mannix_layer_sched.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mannix_layer_sched.sv
// rtl/mannix_layer_sched.sv - in-order layer descriptor dispatcher for the mannix compute engines
// Optional per-wait watchdog is enabled with SCHED_TIMEOUT_EN.
module mannix_layer_sched #(
  parameter int CMD_DEPTH      = 4,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [31:0]          cmd_addr_x,
  input  logic [31:0]          cmd_addr_y,
  input  logic [31:0]          cmd_addr_z,
  output logic [31:0]          unit_addr_x,
  output logic [31:0]          unit_addr_y,
  output logic [31:0]          unit_addr_z,
  output logic                 cnn_go,
  output logic                 pool_go,
  output logic                 fc_go,
  output logic                 activ_go,
  input  logic                 cnn_busy,
  input  logic                 pool_busy,
  input  logic                 fc_done,
  input  logic                 activ_done,
  output logic                 sched_busy,
  output logic [CNT_WIDTH-1:0] done_cnt,
  output logic                 irq,
  output logic                 sched_err
);
  localparam int PW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE, S_RETIRE} state_t;
  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
  } desc_t;

  desc_t                fifo_mem [CMD_DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  state_t               state_q, state_d;
  desc_t                cur_q, cur_d;
  logic [CNT_WIDTH-1:0] done_cnt_q, done_cnt_d;
  logic                 fc_done_q, activ_done_q;
  logic                 push, pop, fifo_empty, fifo_full;
  logic                 eng_busy, done_edge, complete, in_wait, wait_exit;
  logic                 retire_ok, timeout_hit;

  assign fifo_full  = (count_q == CW'(CMD_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign cmd_ready  = ~fifo_full;
  assign push       = cmd_valid & ~fifo_full;

  // op[0] picks POOL over CNN and ACTIV over FC; op[1] marks the done-level engines
  assign eng_busy  = cur_q.op[0] ? pool_busy : cnn_busy;
  assign done_edge = cur_q.op[0] ? (activ_done & ~activ_done_q) : (fc_done & ~fc_done_q);
  assign complete  = cur_q.op[1] ? done_edge : ~eng_busy;
  assign in_wait   = (state_q == S_WAIT_ACK) || (state_q == S_WAIT_DONE);
  assign wait_exit = (state_q == S_WAIT_ACK) ? eng_busy : complete;

  assign wr_ptr_d = wr_ptr_q + PW'(push);
  assign rd_ptr_d = rd_ptr_q + PW'(pop);
  assign count_d  = count_q + CW'(push) - CW'(pop);

  assign unit_addr_x = cur_q.x;
  assign unit_addr_y = cur_q.y;
  assign unit_addr_z = cur_q.z;
  assign done_cnt    = done_cnt_q;
  assign sched_busy  = !((state_q == S_IDLE) && fifo_empty);

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    done_cnt_d = done_cnt_q;
    pop        = 1'b0;
    cnn_go     = 1'b0;
    pool_go    = 1'b0;
    fc_go      = 1'b0;
    activ_go   = 1'b0;
    irq        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          cur_d   = fifo_mem[rd_ptr_q];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        case (cur_q.op)
          2'd0:    cnn_go   = 1'b1;
          2'd1:    pool_go  = 1'b1;
          2'd2:    fc_go    = 1'b1;
          default: activ_go = 1'b1;
        endcase
        state_d = cur_q.op[1] ? S_WAIT_DONE : S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (eng_busy) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (complete) state_d = S_RETIRE;
      end
      S_RETIRE: begin
        if (retire_ok) done_cnt_d = done_cnt_q + CNT_WIDTH'(1);
        irq     = fifo_empty;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (timeout_hit) state_d = S_RETIRE;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= '{op: cmd_op, x: cmd_addr_x, y: cmd_addr_y, z: cmd_addr_z};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      cur_q        <= '0;
      done_cnt_q   <= '0;
      fc_done_q    <= 1'b0;
      activ_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      cur_q        <= cur_d;
      done_cnt_q   <= done_cnt_d;
      fc_done_q    <= fc_done;
      activ_done_q <= activ_done;
    end
  end

`ifdef SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          timeout_q, err_q;

  // counter is zero on the first cycle of each wait state, so the limit is hit on its last cycle
  assign timeout_hit = in_wait && !wait_exit && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign tmo_d       = (in_wait && !wait_exit) ? tmo_q + TW'(1) : '0;
  assign retire_ok   = ~timeout_q;
  assign sched_err   = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q     <= '0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      tmo_q     <= tmo_d;
      timeout_q <= timeout_hit;
      err_q     <= err_q | timeout_hit;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo  = in_wait ^ wait_exit ^ (TIMEOUT_CYCLES == 0);
  assign timeout_hit = 1'b0;
  assign retire_ok   = 1'b1;
  assign sched_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mannix_layer_sched.sv
// tb/tb_mannix_layer_sched.sv - directed scoreboard bench for mannix_layer_sched
module tb_mannix_layer_sched;
  localparam int CW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd_op = '0;
  logic [31:0]   cmd_addr_x = '0, cmd_addr_y = '0, cmd_addr_z = '0;
  logic          cmd_ready;
  logic [31:0]   unit_addr_x, unit_addr_y, unit_addr_z;
  logic          cnn_go, pool_go, fc_go, activ_go;
  logic          cnn_busy, pool_busy, fc_done, activ_done;
  logic          sched_busy, irq, sched_err;
  logic [CW-1:0] done_cnt;

  logic m_cnn_busy = 1'b0, m_pool_busy = 1'b0, m_fc_done = 1'b0, m_activ_done = 1'b0;
  logic a_cnn_busy = 1'b0, a_pool_busy = 1'b0, a_fc_done = 1'b0, a_activ_done = 1'b0;
  assign cnn_busy   = m_cnn_busy | a_cnn_busy;
  assign pool_busy  = m_pool_busy | a_pool_busy;
  assign fc_done    = m_fc_done | a_fc_done;
  assign activ_done = m_activ_done | a_activ_done;

  int            n_cmp = 0, n_err = 0, irq_seen = 0, go_seen = 0, g0;
  bit            auto_eng = 1'b0;
  logic [CW-1:0] exp_done = '0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] x, y, z;
  } exp_t;
  exp_t sb[$];

  logic [3:0] gos;
  assign gos = {activ_go, fc_go, pool_go, cnn_go};

  mannix_layer_sched #(.CMD_DEPTH(4), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr_x(cmd_addr_x), .cmd_addr_y(cmd_addr_y), .cmd_addr_z(cmd_addr_z),
    .unit_addr_x(unit_addr_x), .unit_addr_y(unit_addr_y), .unit_addr_z(unit_addr_z),
    .cnn_go(cnn_go), .pool_go(pool_go), .fc_go(fc_go), .activ_go(activ_go),
    .cnn_busy(cnn_busy), .pool_busy(pool_busy), .fc_done(fc_done), .activ_done(activ_done),
    .sched_busy(sched_busy), .done_cnt(done_cnt), .irq(irq), .sched_err(sched_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // drives one push for a cycle; accepted descriptors are queued as expected dispatches
  task automatic push(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] z, input bit accept);
    exp_t e;
    cmd_valid = 1'b1;
    cmd_op = op; cmd_addr_x = x; cmd_addr_y = y; cmd_addr_z = z;
    @(negedge clk);
    chk("cmd_ready", 64'(cmd_ready), 64'(accept));
    if (accept) begin
      e.op = op; e.x = x; e.y = y; e.z = z;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    @(negedge clk);
    while (sched_busy && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk("drain_bound", 64'(sched_busy), 64'd0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (irq) irq_seen++;
      if (gos != 4'b0) begin
        go_seen++;
        chk("go_onehot", 64'($onehot(gos)), 64'd1);
        if (sb.size() == 0) chk("go_unexpected", 64'(gos), 64'd0);
        else begin
          e = sb.pop_front();
          chk("go_engine", 64'(gos), 64'(4'b0001 << e.op));
          chk("go_addr_x", 64'(unit_addr_x), 64'(e.x));
          chk("go_addr_y", 64'(unit_addr_y), 64'(e.y));
          chk("go_addr_z", 64'(unit_addr_z), 64'(e.z));
        end
      end
    end
  end

  // simple engine stand-in: busy pulse for CNN/POOL, done pulse for FC/ACTIV
  initial begin : responder
    bit second;
    forever begin
      @(negedge clk);
      if (auto_eng && !rst && (gos != 4'b0)) begin
        second = pool_go | activ_go;
        if (cnn_go || pool_go) begin
          repeat (2) @(posedge clk);
          #1;
          if (second) a_pool_busy = 1'b1; else a_cnn_busy = 1'b1;
          repeat (3) @(posedge clk);
          #1;
          a_pool_busy = 1'b0; a_cnn_busy = 1'b0;
        end else begin
          repeat (2) @(posedge clk);
          #1;
          if (second) a_activ_done = 1'b1; else a_fc_done = 1'b1;
          repeat (3) @(posedge clk);
          #1;
          a_activ_done = 1'b0; a_fc_done = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    adv(2);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_sched_busy", 64'(sched_busy), 64'd0);
    chk("rst_done_cnt", 64'(done_cnt), 64'd0);
    chk("rst_gos", 64'(gos), 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);
    chk("rst_err", 64'(sched_err), 64'd0);
    chk("rst_addr", 64'({unit_addr_x, unit_addr_y} | 64'(unit_addr_z)), 64'd0);
    adv(1);

    // single FC layer with exact latency
    irq_seen = 0;
    push(2'd2, 32'h100, 32'h200, 32'h300, 1'b1);
    @(negedge clk);
    chk("t1_no_go_T1", 64'(gos), 64'd0);
    adv(1);
    @(negedge clk);
    chk("t1_fc_go_T2", 64'(fc_go), 64'd1);
    chk("t1_addr_x", 64'(unit_addr_x), 64'h100);
    chk("t1_addr_z", 64'(unit_addr_z), 64'h300);
    adv(1);
    @(negedge clk);
    chk("t1_fc_go_T3", 64'(fc_go), 64'd0);
    chk("t1_busy_T3", 64'(sched_busy), 64'd1);
    adv(7);
    m_fc_done = 1'b1;
    @(negedge clk);
    chk("t1_irq_T10", 64'(irq), 64'd0);
    adv(1);
    @(negedge clk);
    chk("t1_irq_T11", 64'(irq), 64'd1);
    chk("t1_cnt_T11", 64'(done_cnt), 64'(exp_done));
    exp_done = exp_done + CW'(1);
    adv(1);
    @(negedge clk);
    chk("t1_irq_T12", 64'(irq), 64'd0);
    chk("t1_cnt_T12", 64'(done_cnt), 64'(exp_done));
    chk("t1_idle_T12", 64'(sched_busy), 64'd0);
    m_fc_done = 1'b0;
    adv(1);

    // CNN, POOL, FC, ACTIV back to back; CNN held until busy rises and falls
    irq_seen = 0;
    push(2'd0, 32'h1000, 32'h1004, 32'h1008, 1'b1);
    push(2'd1, 32'h2000, 32'h2004, 32'h2008, 1'b1);
    push(2'd2, 32'h3000, 32'h3004, 32'h3008, 1'b1);
    push(2'd3, 32'h4000, 32'h4004, 32'h4008, 1'b1);
    adv(4);
    @(negedge clk);
    chk("t2_cnn_no_busy", 64'(done_cnt), 64'(exp_done));
    chk("t2_pool_held", 64'(pool_go), 64'd0);
    m_cnn_busy = 1'b1;
    adv(3);
    @(negedge clk);
    chk("t2_cnn_busy_hi", 64'(done_cnt), 64'(exp_done));
    auto_eng = 1'b1;
    m_cnn_busy = 1'b0;
    wait_idle(200);
    exp_done = exp_done + CW'(4);
    chk("t2_done_cnt", 64'(done_cnt), 64'(exp_done));
    chk("t2_irq_count", 64'(irq_seen), 64'd1);
    chk("t2_sb_empty", 64'(sb.size()), 64'd0);

    // fill the FIFO behind a stalled CNN; done_cnt wraps through 0 here
    auto_eng = 1'b0;
    irq_seen = 0;
    push(2'd0, 32'hA0, 32'hA4, 32'hA8, 1'b1);
    push(2'd1, 32'hB0, 32'hB4, 32'hB8, 1'b1);
    push(2'd2, 32'hC0, 32'hC4, 32'hC8, 1'b1);
    push(2'd3, 32'hD0, 32'hD4, 32'hD8, 1'b1);
    push(2'd0, 32'hE0, 32'hE4, 32'hE8, 1'b1);
    push(2'd2, 32'hF0, 32'hF4, 32'hF8, 1'b0);
    push(2'd2, 32'hF0, 32'hF4, 32'hF8, 1'b0);
    @(negedge clk);
    chk("t3_full_ready", 64'(cmd_ready), 64'd0);
    chk("t3_addr_stable", 64'(unit_addr_x), 64'hA0);
    auto_eng = 1'b1;
    m_cnn_busy = 1'b1;
    adv(2);
    m_cnn_busy = 1'b0;
    wait_idle(400);
    exp_done = exp_done + CW'(5);
    chk("t3_done_wrap", 64'(done_cnt), 64'(exp_done));
    chk("t3_irq_count", 64'(irq_seen), 64'd1);
    chk("t3_sb_empty", 64'(sb.size()), 64'd0);

    // fc_done stuck high from before: only a fresh rising edge completes
    auto_eng = 1'b0;
    irq_seen = 0;
    m_fc_done = 1'b1;
    adv(2);
    push(2'd2, 32'h5000, 32'h5004, 32'h5008, 1'b1);
    adv(6);
    @(negedge clk);
    chk("t4_stuck_cnt", 64'(done_cnt), 64'(exp_done));
    chk("t4_stuck_busy", 64'(sched_busy), 64'd1);
    m_fc_done = 1'b0;
    adv(2);
    m_fc_done = 1'b1;
    @(negedge clk);
    chk("t4_irq_edge", 64'(irq), 64'd0);
    adv(1);
    @(negedge clk);
    chk("t4_irq_retire", 64'(irq), 64'd1);
    exp_done = exp_done + CW'(1);
    adv(1);
    @(negedge clk);
    chk("t4_done_cnt", 64'(done_cnt), 64'(exp_done));
    m_fc_done = 1'b0;
    adv(1);

    // reset while ACTIV waits with two queued
    push(2'd3, 32'h6000, 32'h6004, 32'h6008, 1'b1);
    push(2'd0, 32'h7000, 32'h7004, 32'h7008, 1'b1);
    push(2'd2, 32'h8000, 32'h8004, 32'h8008, 1'b1);
    rst = 1'b1;
    adv(1);
    rst = 1'b0;
    sb.delete();
    exp_done = '0;
    @(negedge clk);
    chk("t5_ready", 64'(cmd_ready), 64'd1);
    chk("t5_busy", 64'(sched_busy), 64'd0);
    chk("t5_done_cnt", 64'(done_cnt), 64'd0);
    chk("t5_addr", 64'(unit_addr_x), 64'd0);
    g0 = go_seen;
    adv(10);
    @(negedge clk);
    chk("t5_no_strobes", 64'(go_seen), 64'(g0));
    chk("t5_still_idle", 64'(sched_busy), 64'd0);
    adv(1);

`ifdef SCHED_TIMEOUT_EN
    // CNN never acknowledges: watchdog retires it, POOL then runs normally
    irq_seen = 0;
    push(2'd0, 32'h9000, 32'h9004, 32'h9008, 1'b1);
    push(2'd1, 32'h9100, 32'h9104, 32'h9108, 1'b1);
    adv(16);
    @(negedge clk);
    chk("t6_err_before", 64'(sched_err), 64'd0);
    adv(1);
    @(negedge clk);
    chk("t6_err_set", 64'(sched_err), 64'd1);
    chk("t6_cnt_kept", 64'(done_cnt), 64'(exp_done));
    chk("t6_no_irq", 64'(irq), 64'd0);
    auto_eng = 1'b1;
    wait_idle(200);
    exp_done = exp_done + CW'(1);
    chk("t6_done_cnt", 64'(done_cnt), 64'(exp_done));
    chk("t6_err_sticky", 64'(sched_err), 64'd1);
    chk("t6_irq_count", 64'(irq_seen), 64'd1);
`else
    chk("err_tied_low", 64'(sched_err), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
